// File: rtl/pipeline_pkg.sv
// Shared pipeline widths, result-select encodings and MEM-stage FSM states.
// No logic; imported by the MEM stage and its MEM/WB register.
package pipeline_pkg;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 15;
  localparam int RD_W   = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears every field.
// Latency 1; no backpressure, loads on every rising edge.
module mem_wb_reg #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int RD_W   = pipeline_pkg::RD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              regWrite,
  input  logic [1:0]        resultSrc,
  input  logic [RD_W-1:0]   rd,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] readData,
  output logic              regWriteW,
  output logic [1:0]        resultSrcW,
  output logic [RD_W-1:0]   rdW,
  output logic [DATA_W-1:0] aluResultW,
  output logic [DATA_W-1:0] readDataW
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bubble) begin
      regWriteW  <= 1'b0;
      resultSrcW <= '0;
      rdW        <= '0;
      aluResultW <= '0;
      readDataW  <= '0;
    end else begin
      regWriteW  <= regWrite;
      resultSrcW <= resultSrc;
      rdW        <= rd;
      aluResultW <= aluResult;
      readDataW  <= readData;
    end
  end
endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues data-memory accesses and feeds the MEM/WB register.
// Latency 1 for ALU ops, >=3 for memory ops (timeout abort after TIMEOUT BUSY cycles).
// Backpressure: StallM freezes upstream from issue until the access completes.
module memory_stage #(
  parameter int DATA_W  = pipeline_pkg::DATA_W,
  parameter int ADDR_W  = pipeline_pkg::ADDR_W,
  parameter int RD_W    = pipeline_pkg::RD_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [RD_W-1:0]   RDM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic              Cant_ByteM,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [RD_W-1:0]   RDW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic              mem_err,
  output logic [15:0]       stall_cnt
);
  import pipeline_pkg::*;

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t        state;
  logic [TMO_W-1:0]  tmoCnt;
  logic [DATA_W-1:0] capData;
  logic              isAccess;

  assign isAccess = MemWriteM | (ResultSrcM == RES_MEM);
  // Gated by reset so an in-flight access releases the pipeline immediately.
  assign StallM = reset & (((state == IDLE) & isAccess) | (state == BUSY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tmoCnt    <= '0;
      capData   <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (StallM && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      case (state)
        IDLE: if (isAccess) begin
          mem_req   <= 1'b1;
          mem_we    <= MemWriteM;
          mem_byte  <= Cant_ByteM;
          mem_addr  <= ALUResultM[ADDR_W-1:0];
          mem_wdata <= Cant_ByteM ? {{(DATA_W-8){1'b0}}, WriteDataM[7:0]} : WriteDataM;
          tmoCnt    <= '0;
          state     <= BUSY;
        end
        BUSY: begin
          if (mem_ack) begin
            capData <= mem_byte ? {{(DATA_W-8){1'b0}}, mem_rdata[7:0]} : mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (tmoCnt == TMO_W'(TIMEOUT - 1)) begin
            capData <= '0;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            state   <= DONE;
          end else begin
            tmoCnt <= tmoCnt + TMO_W'(1);
          end
        end
        // Inputs still hold the stalled instruction; it retires here without re-issue.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) u_mem_wb_reg (
    .clk       (clk),
    .reset     (reset),
    .bubble    (StallM),
    .regWrite  (RegWriteM),
    .resultSrc (ResultSrcM),
    .rd        (RDM),
    .aluResult (ALUResultM),
    .readData  ((state == DONE) ? capData : '0),
    .regWriteW (RegWriteW),
    .resultSrcW(ResultSrcW),
    .rdW       (RDW),
    .aluResultW(ALUResultW),
    .readDataW (ReadDataW)
  );
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed ops, memory responder, WB and request checkers.
module tb_memory_stage;
  import pipeline_pkg::*;

  localparam int DW = 19;
  localparam int AW = 15;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWriteM, MemWriteM, Cant_ByteM;
  logic [1:0]    ResultSrcM;
  logic [RW-1:0] RDM;
  logic [DW-1:0] WriteDataM, ALUResultM;
  logic          mem_req, mem_we, mem_byte;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          StallM, RegWriteW, mem_err;
  logic [1:0]    ResultSrcW;
  logic [RW-1:0] RDW;
  logic [DW-1:0] ALUResultW, ReadDataW;
  logic [15:0]   stall_cnt;

  logic ackM = 1'b0, spurAck = 1'b0, inV = 1'b0, pending = 1'b0;
  int   ackDly = 99, busyCnt = 0;
  int   nCmp = 0, nErr = 0;

  assign mem_ack = ackM | spurAck;

  typedef struct packed {
    logic rw; logic [1:0] src; logic [RW-1:0] rd; logic [DW-1:0] alu; logic [DW-1:0] rdData;
  } wbExp_t;
  typedef struct packed {
    logic we; logic byt; logic [AW-1:0] addr; logic [DW-1:0] wdata;
  } reqExp_t;
  wbExp_t  wbQ[$];
  reqExp_t reqQ[$];

  memory_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RDM(RDM),
    .WriteDataM(WriteDataM), .ALUResultM(ALUResultM), .Cant_ByteM(Cant_ByteM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RDW(RDW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // WB monitor: an instruction accepted with StallM low shows up in W after the next edge.
  initial forever begin
    @(negedge clk);
    if (pending) begin
      if (wbQ.size() == 0) begin
        nCmp++; nErr++;
        $display("FAIL wb_unexpected: got retire expected none");
      end else begin
        wbExp_t e;
        e = wbQ.pop_front();
        chk("wb_regwrite", 32'(RegWriteW), 32'(e.rw));
        chk("wb_resultsrc", 32'(ResultSrcW), 32'(e.src));
        chk("wb_rd", 32'(RDW), 32'(e.rd));
        chk("wb_aluresult", 32'(ALUResultW), 32'(e.alu));
        chk("wb_readdata", 32'(ReadDataW), 32'(e.rdData));
      end
    end
    pending = inV && !StallM && reset;
  end

  // Memory responder and request checker.
  initial forever begin
    @(negedge clk);
    if (mem_req) begin
      if (busyCnt == 0) begin
        if (reqQ.size() == 0) begin
          nCmp++; nErr++;
          $display("FAIL req_unexpected: got request expected none");
        end else begin
          reqExp_t r;
          r = reqQ.pop_front();
          chk("req_we", 32'(mem_we), 32'(r.we));
          chk("req_byte", 32'(mem_byte), 32'(r.byt));
          chk("req_addr", 32'(mem_addr), 32'(r.addr));
          chk("req_wdata", 32'(mem_wdata), 32'(r.wdata));
        end
      end
      ackM = (busyCnt == ackDly);
      busyCnt++;
    end else begin
      ackM = 1'b0;
      busyCnt = 0;
    end
  end

  task automatic setIn(input logic rw, input logic mw, input logic [1:0] src, input logic [RW-1:0] rd,
                       input logic [DW-1:0] wd, input logic [DW-1:0] alu, input logic byt);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = src; RDM = rd;
    WriteDataM = wd; ALUResultM = alu; Cant_ByteM = byt;
  endtask

  task automatic nop();
    @(posedge clk); #1;
    setIn(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0);
    inV = 1'b0;
  endtask

  task automatic issue(input logic rw, input logic mw, input logic [1:0] src, input logic [RW-1:0] rd,
                       input logic [DW-1:0] wd, input logic [DW-1:0] alu, input logic byt,
                       input int dly, input logic [DW-1:0] rdat, input int expStall,
                       input logic [AW-1:0] expAddr, input logic [DW-1:0] expWdata,
                       input logic [DW-1:0] expRd);
    wbExp_t  w;
    reqExp_t r;
    int      n;
    @(posedge clk); #1;
    setIn(rw, mw, src, rd, wd, alu, byt);
    mem_rdata = rdat;
    ackDly = dly;
    inV = 1'b1;
    w.rw = rw; w.src = src; w.rd = rd; w.alu = alu; w.rdData = expRd;
    wbQ.push_back(w);
    if (expStall > 0) begin
      r.we = mw; r.byt = byt; r.addr = expAddr; r.wdata = expWdata;
      reqQ.push_back(r);
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!StallM) break;
      n++;
    end
    chk("stall_cycles", 32'(n), 32'(expStall));
  endtask

  initial begin
    reset = 1'b0;
    mem_rdata = '0;
    setIn(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_regwrite_w", 32'(RegWriteW), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // ALU op passes straight through
    issue(1'b1, 1'b0, 2'b00, 5'd3, 19'd0, 19'd30, 1'b0, 99, 19'd0, 0, 15'd0, 19'd0, 19'd0);
    chk("alu_mem_req", 32'(mem_req), 32'd0);
    // word load, ack in third BUSY cycle
    issue(1'b1, 1'b0, 2'b01, 5'd5, 19'h00011, 19'd100, 1'b0, 2, 19'h4ABCD, 4, 15'd100, 19'h00011, 19'h4ABCD);
    chk("wload_stall_cnt", 32'(stall_cnt), 32'd4);
    // byte store
    issue(1'b0, 1'b1, 2'b00, 5'd0, 19'h12345, 19'd7, 1'b1, 0, 19'd0, 2, 15'd7, 19'h00045, 19'd0);
    chk("bstore_stall_cnt", 32'(stall_cnt), 32'd6);
    // byte load, address truncated to 15 bits
    issue(1'b1, 1'b0, 2'b01, 5'd9, 19'd0, 19'h48010, 1'b1, 1, 19'h7FFF3, 3, 15'h0010, 19'd0, 19'h000F3);
    chk("bload_stall_cnt", 32'(stall_cnt), 32'd9);
    // store and load both flagged: store wins
    issue(1'b0, 1'b1, 2'b01, 5'd2, 19'h7FFFF, 19'h00200, 1'b0, 0, 19'd0, 2, 15'h0200, 19'h7FFFF, 19'd0);
    chk("both_stall_cnt", 32'(stall_cnt), 32'd11);
    chk("pre_tmo_err", 32'(mem_err), 32'd0);
    // timeout: no ack ever
    issue(1'b1, 1'b0, 2'b01, 5'd7, 19'd0, 19'd55, 1'b0, 99, 19'h1234, 17, 15'd55, 19'd0, 19'd0);
    chk("tmo_mem_req", 32'(mem_req), 32'd0);
    chk("tmo_stall_cnt", 32'(stall_cnt), 32'd28);
    // spurious ack in IDLE
    nop();
    spurAck = 1'b1;
    mem_rdata = 19'h7FFFF;
    @(negedge clk);
    chk("spur_mem_req", 32'(mem_req), 32'd0);
    chk("spur_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1 spurAck = 1'b0;
    @(negedge clk);
    chk("spur_readdata", 32'(ReadDataW), 32'd0);
    chk("spur_mem_req2", 32'(mem_req), 32'd0);
    chk("spur_stall_cnt", 32'(stall_cnt), 32'd28);
    chk("tmo_err_sticky", 32'(mem_err), 32'd1);
    // other ResultSrc codes pass through
    issue(1'b1, 1'b0, 2'b10, 5'd31, 19'd0, 19'h7FFFF, 1'b0, 99, 19'd0, 0, 15'd0, 19'd0, 19'd0);
    nop();
    @(negedge clk);

    // reset in the middle of an access
    @(posedge clk); #1;
    setIn(1'b1, 1'b0, 2'b01, 5'd4, 19'd0, 19'h00100, 1'b0);
    ackDly = 99;
    begin
      reqExp_t r;
      r.we = 1'b0; r.byt = 1'b0; r.addr = 15'h0100; r.wdata = 19'd0;
      reqQ.push_back(r);
    end
    repeat (3) @(negedge clk);
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_stall", 32'(StallM), 32'd0);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
    chk("arst_regwrite_w", 32'(RegWriteW), 32'd0);
    chk("arst_rd_w", 32'(RDW), 32'd0);
    chk("arst_alu_w", 32'(ALUResultW), 32'd0);
    chk("arst_src_w", 32'(ResultSrcW), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_mem_err", 32'(mem_err), 32'd0);
    nop();
    @(posedge clk); #1 reset = 1'b1;
    // pipeline recovers after reset
    issue(1'b1, 1'b0, 2'b00, 5'd1, 19'd0, 19'd1, 1'b0, 99, 19'd0, 0, 15'd0, 19'd0, 19'd0);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    nop();
    repeat (2) @(negedge clk);
    chk("wb_queue_drained", 32'(wbQ.size()), 32'd0);
    chk("req_queue_drained", 32'(reqQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes the execute stage's M-register outputs: RegWriteM, MemWriteM, ResultSrcM, RDM, WriteDataM, ALUResultM and Cant_ByteM.
- Drives a handshaked data-memory port, stalls the upstream pipeline while an access is outstanding, and holds the MEM/WB pipeline register that feeds writeback.

Parameters:
- DATA_W, 19, datapath width; matches the ALU result and register width.
- ADDR_W, 15, data-memory address width; the address is ALUResultM[ADDR_W-1:0].
- RD_W, 5, destination-register index width.
- TIMEOUT, 16, maximum BUSY cycles to wait for mem_ack before aborting.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- RegWriteM  in  1  register-write enable from execute.
- MemWriteM  in  1  store enable.
- ResultSrcM  in  2  result select; 2'b01 = load; other codes pass through.
- RDM  in  RD_W  destination register.
- WriteDataM  in  DATA_W  store data.
- ALUResultM  in  DATA_W  address or ALU result.
- Cant_ByteM  in  1  1 = byte access, 0 = full word.
- mem_req  out  1  access request, registered.
- mem_we  out  1  1 = write.
- mem_byte  out  1  byte-access qualifier.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  single-cycle completion pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- StallM  out  1  freeze the IF/ID/EX registers and execute's M register.
- RegWriteW  out  1  MEM/WB register.
- ResultSrcW  out  2  MEM/WB register.
- RDW  out  RD_W  MEM/WB register.
- ALUResultW  out  DATA_W  MEM/WB register.
- ReadDataW  out  DATA_W  MEM/WB register.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  16  saturating count of stalled cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_byte=0, mem_addr=0, mem_wdata=0.
  - All W outputs 0; mem_err=0; stall_cnt=0; timeout counter=0.
  - Applies mid-access: the request drops immediately and the in-flight instruction is discarded.
- Access condition: access = MemWriteM | (ResultSrcM==2'b01). If both are true, the store takes precedence.
- Non-access instruction in IDLE: latency 1. The W register loads RegWriteM, ResultSrcM, RDM, ALUResultM; ReadDataW<=0; StallM=0.
- FSM IDLE -> BUSY -> DONE -> IDLE.
  - IDLE with access:
    - StallM=1, combinational.
    - Register mem_req=1, mem_we=MemWriteM, mem_byte=Cant_ByteM, mem_addr=ALUResultM[ADDR_W-1:0].
    - mem_wdata = byte ? zero-extended WriteDataM[7:0] : WriteDataM.
    - W register loads a bubble (RegWriteW=0).
    - Next state BUSY.
  - BUSY:
    - StallM=1; request fields held stable; timeout counter increments.
    - On mem_ack: capture read data (byte load = zero-extended mem_rdata[7:0], word = mem_rdata), mem_req<=0, go to DONE.
    - On counter==TIMEOUT-1 without ack: mem_req<=0, mem_err<=1, captured data=0, go to DONE.
    - W register holds a bubble.
  - DONE:
    - StallM=0; inputs are still the stalled instruction.
    - W register loads control fields and ALUResultM, and ReadDataW=captured data.
    - Next state IDLE unconditionally; access is not re-evaluated here, so no double issue.
- Minimum memory-op latency: 3 cycles (ack in the first BUSY cycle).
- A store writes RegWriteW as presented by RegWriteM (normally 0).
- mem_ack outside BUSY is ignored.
- stall_cnt increments in every cycle with StallM=1 and saturates at 16'hFFFF.
- mem_err clears only on reset.

Decomposition:
- Shared package pipeline_pkg:
  - DATA_W, ADDR_W, RD_W.
  - ResultSrc encodings: RES_ALU=2'b00, RES_MEM=2'b01.
  - mem_state_t enum {IDLE, BUSY, DONE}.
- One natural sub-module, mem_wb_reg: the MEM/WB pipeline register with bubble insert. Everything else is inline.

Test Plan:
- Reset then ALU op: RegWriteM=1, ResultSrcM=00, RDM=3, ALUResultM=30 -> next edge RegWriteW=1, RDW=3, ALUResultW=30, StallM=0, mem_req=0.
- Word load: ResultSrcM=01, ALUResultM=19'd100, Cant_ByteM=0; ack after 2 BUSY cycles with mem_rdata=19'h4ABCD -> mem_addr=100, mem_we=0; StallM high for 4 cycles; then ReadDataW=19'h4ABCD, RDW as given, stall_cnt=4.
- Byte store: MemWriteM=1, WriteDataM=19'h12345, Cant_ByteM=1, ALUResultM=7 -> mem_we=1, mem_byte=1, mem_wdata=19'h00045, mem_addr=7; after ack, RegWriteW=0.
- Byte load: mem_rdata=19'h7FFF3, Cant_ByteM=1 -> ReadDataW=19'h000F3.
- No ack for TIMEOUT=16 cycles -> mem_req falls, mem_err=1, ReadDataW=0, pipeline resumes; a spurious mem_ack afterwards causes no change.
- reset asserted in BUSY -> mem_req=0 and StallM=0 immediately; state IDLE; W outputs 0.
